sha256_msg_schedule: RTL and testbench

SHA-256 message-schedule generator, directly upstream of the compression-round datapath and its working registers A–H. It accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream. It then emits the 64 schedule words W0..W63, one per accepted handshake, so the round datapath can consume one W per round. A 16-word sliding window holds state, so storage is 16x32 bits regardless of round count.

---
 rtl/sha256_msg_schedule.sv | 116 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: loads one 512-bit block as 16 words,
// then streams W0..W63 from a 16-word sliding window, one per handshake.
module sha256_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              blk_valid,
  input  logic [WORD_W-1:0] blk_word,
  output logic              blk_ready,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [5:0]        w_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        load_cnt;
  logic [WORD_W-1:0] window [16];
  logic [WORD_W-1:0] w_next;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next schedule word W_(t+16) from the window that currently holds W_t..W_(t+15).
  assign w_next = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

  // Window head is always the word on offer; it is a flop, so no input-to-output path.
  assign w_data = window[0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      load_cnt  <= '0;
      w_idx     <= '0;
      blk_ready <= 1'b0;
      w_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      // NOTE: the window is cleared on reset so an aborted block leaves no residue
      // on w_data; this costs a reset net on 512 flops, which is accepted here.
      for (int k = 0; k < 16; k++) window[k] <= '0;
    end else begin
      // NOTE: all state updates use <= so every branch reads pre-edge values;
      // the window shift and w_next below depend on that.
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            load_cnt  <= '0;
            blk_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end

        LOAD: begin
          if (blk_valid) begin
            window[load_cnt] <= blk_word;
            load_cnt         <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              state     <= RUN;
              blk_ready <= 1'b0;
              w_valid   <= 1'b1;
              w_idx     <= '0;
            end
          end
        end

        RUN: begin
          if (w_ready) begin
            for (int k = 0; k < 15; k++) window[k] <= window[k+1];
            window[15] <= w_next;
            w_idx      <= w_idx + 6'd1;
            if (w_idx == 6'(ROUNDS - 1)) begin
              state   <= DONE;
              w_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          w_idx <= '0;
        end

        default: begin
          state     <= IDLE;
          blk_ready <= 1'b0;
          w_valid   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: directed block sequences with
// randomized backpressure and data, checked against a textbook schedule model.
module tb_sha256_msg_schedule;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        blk_valid = 1'b0;
  logic [31:0] blk_word = '0;
  logic        blk_ready;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_data;
  logic [5:0]  w_idx;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];

  sha256_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut (
    .CLK(CLK), .RST(RST), .start(start), .blk_valid(blk_valid), .blk_word(blk_word),
    .blk_ready(blk_ready), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_idx(w_idx), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: the FIPS 180-4 schedule recurrence over a full 64-entry array.
  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
    for (int t = 16; t < 64; t++) begin
      logic [31:0] s0, s1;
      s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 32'h6162_6380;
    msg[15] = 32'h0000_0018;
    build_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_blk_ready"}, 32'(blk_ready), 32'd0);
    check({tag, "_w_valid"},   32'(w_valid),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_w_data"},    w_data,         32'd0);
    check({tag, "_w_idx"},     32'(w_idx),     32'd0);
  endtask

  // Pulse start in IDLE, then feed msg[] with an optional gap before word gap_at.
  task automatic load_block(input int gap_at, input int gap_len, input bit hold_valid);
    start = 1'b1;
    step();
    start = 1'b0;
    check("load_blk_ready", 32'(blk_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        blk_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          step();
          check("gap_w_valid", 32'(w_valid), 32'd0);
          check("gap_blk_ready", 32'(blk_ready), 32'd1);
        end
      end
      blk_valid = 1'b1;
      blk_word  = msg[i];
      check("load_w_valid_low", 32'(w_valid), 32'd0);
      step();
    end
    if (hold_valid) blk_word = 32'hDEAD_BEEF;
    else blk_valid = 1'b0;
    check("first_w_valid", 32'(w_valid), 32'd1);
  endtask

  // Drain 64 words; returns early (after a mid-run reset) when abort_at >= 0.
  task automatic run_block(input bit rand_ready, input bit abc, input int start_at,
                           input int abort_at, input bit start_on_done);
    int t = 0;
    int cycles = 0;
    while (t < 64 && cycles < 2000) begin
      if (t == abort_at) begin
        RST = 1'b1;
        #1;
        check_all_zero("abort");
        step();
        RST = 1'b0;
        w_ready = 1'b0;
        step();
        return;
      end
      w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start   = (t == start_at);
      check("run_w_valid", 32'(w_valid), 32'd1);
      check("run_w_idx", 32'(w_idx), 32'(t));
      check("run_w_data", w_data, exp_w[t]);
      check("run_blk_ready", 32'(blk_ready), 32'd0);
      check("run_done_low", 32'(done), 32'd0);
      if (abc && t == 16) check("abc_W16", w_data, 32'h6162_6380);
      if (abc && t == 17) check("abc_W17", w_data, 32'h000F_0000);
      step();
      start = 1'b0;
      if (w_ready) t++;
      cycles++;
    end
    check("run_no_timeout", 32'(t), 32'd64);
    w_ready = 1'b0;
    start = start_on_done;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_w_valid", 32'(w_valid), 32'd0);
    step();
    start = 1'b0;
    check("idle_done_low", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_blk_ready", 32'(blk_ready), 32'd0);
    check("idle_w_idx", 32'(w_idx), 32'd0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    step();
    RST = 1'b0;
    step();
    check_all_zero("post_reset");

    // "abc" block, consumer always ready.
    set_abc();
    load_block(-1, 0, 1'b0);
    run_block(1'b0, 1'b1, -1, -1, 1'b0);

    // Same block under random backpressure.
    load_block(-1, 0, 1'b0);
    run_block(1'b1, 1'b1, -1, -1, 1'b0);

    // Three idle cycles between M7 and M8.
    load_block(8, 3, 1'b0);
    run_block(1'b0, 1'b1, -1, -1, 1'b0);

    // start at w_idx=20, blk_valid held through RUN, start coincident with done.
    load_block(-1, 0, 1'b1);
    run_block(1'b0, 1'b1, 20, -1, 1'b1);
    check("idle_ignores_blk_valid", 32'(blk_ready), 32'd0);
    blk_valid = 1'b0;
    step();
    check("start_on_done_ignored", 32'(busy), 32'd0);

    // Abort at w_idx=30, then the all-ones block.
    load_block(-1, 0, 1'b0);
    run_block(1'b0, 1'b0, -1, 30, 1'b0);
    check("after_abort_done_cnt", 32'(done_cnt), 32'd4);
    for (int i = 0; i < 16; i++) msg[i] = 32'hFFFF_FFFF;
    build_model();
    load_block(-1, 0, 1'b0);
    run_block(1'b1, 1'b0, -1, -1, 1'b0);

    // Two random blocks back to back: second start the cycle after done.
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    build_model();
    load_block(-1, 0, 1'b0);
    run_block(1'b1, 1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    build_model();
    load_block(-1, 0, 1'b0);
    run_block(1'b0, 1'b0, -1, -1, 1'b0);

    step();
    check("total_done_pulses", 32'(done_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
